// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer stimulus and screen blocks.
package la_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } la_state_e;

  typedef enum logic [1:0] {
    DB_ZERO  = 2'd0,
    DB_WAIT1 = 2'd1,
    DB_ONE   = 2'd2,
    DB_WAIT0 = 2'd3
  } db_state_e;

  localparam int unsigned LA_DEPTH = 80;
  localparam int unsigned LA_CH    = 4;
  localparam int unsigned LA_DIV   = 250;

endpackage

// File: rtl/db_fsm.sv
// Push-button debouncer: sw must stay stable for N_CYCLES clocks before the
// debounced level changes; db_tick pulses for one cycle on each debounced rise.
module db_fsm
  import la_pkg::*;
#(
  parameter int unsigned N_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw,
  output logic db_tick
);

  localparam int unsigned CW = (N_CYCLES > 1) ? $clog2(N_CYCLES) : 1;

  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  assign db_tick = tick_q;

  // State, stability counter and tick registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= DB_ZERO;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
    end
  end

  // Next-state: count stable cycles, fall back on any bounce.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    case (state_q)
      DB_ZERO: begin
        if (sw) begin
          state_d = DB_WAIT1;
          cnt_d   = '0;
        end
      end
      DB_WAIT1: begin
        if (!sw) begin
          state_d = DB_ZERO;
        end else if (cnt_q == CW'(N_CYCLES - 1)) begin
          state_d = DB_ONE;
          tick_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DB_ONE: begin
        if (!sw) begin
          state_d = DB_WAIT0;
          cnt_d   = '0;
        end
      end
      DB_WAIT0: begin
        if (sw) begin
          state_d = DB_ONE;
        end else if (cnt_q == CW'(N_CYCLES - 1)) begin
          state_d = DB_ZERO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = DB_ZERO;
    endcase
  end

endmodule

// File: rtl/dual_port_sync_ram.sv
// Simple dual-port RAM: port A writes, port B reads, both synchronous.
// A same-cycle write and read of one address returns the old contents.
module dual_port_sync_ram #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] dout_b
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  // Write port A and registered read port B (read-first through NBA ordering).
  always_ff @(posedge clk) begin
    if (we_a) mem_q[addr_a] <= din_a;
    dout_b <= mem_q[addr_b];
  end

endmodule

// File: rtl/logic_pattern_gen.sv
// 4-channel pattern generator: plays a host-loaded RAM pattern out on out[],
// one sample per DIV clocks, single-shot or looping, started/aborted by key.
module logic_pattern_gen
  import la_pkg::*;
#(
  parameter int unsigned DEPTH     = LA_DEPTH,
  parameter int unsigned AW        = 7,
  parameter int unsigned CH        = LA_CH,
  parameter int unsigned DIV       = LA_DIV,
  parameter int unsigned DB_CYCLES = 500000
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          key,
  input  logic          loop_en,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [CH-1:0] wr_data,
  output logic [CH-1:0] out,
  output logic          busy,
  output logic          done_tick,
  output logic [AW-1:0] sample_idx
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

  la_state_e     state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [CH-1:0] out_q, out_d;
  logic          done_q, done_d;

  logic          key_tick;
  logic          ram_we;
  logic [AW-1:0] nxt_idx;
  logic [AW-1:0] rd_addr;
  logic [CH-1:0] rd_data;

  assign out        = out_q;
  assign busy       = (state_q != IDLE);
  assign done_tick  = done_q;
  assign sample_idx = idx_q;

  assign ram_we  = wr_en && (32'(wr_addr) < DEPTH);
  assign nxt_idx = (idx_q == AW'(DEPTH - 1)) ? '0 : idx_q + 1'b1;
  // Address 0 is prefetched while idle so the LOAD cycle already sees ram[0].
  assign rd_addr = (state_q == PLAY) ? nxt_idx : '0;

  dual_port_sync_ram #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(CH)
  ) u_ram (
    .clk   (clk),
    .we_a  (ram_we),
    .addr_a(wr_addr),
    .din_a (wr_data),
    .addr_b(rd_addr),
    .dout_b(rd_data)
  );

  db_fsm #(
    .N_CYCLES(DB_CYCLES)
  ) u_db (
    .clk    (clk),
    .reset_n(reset_n),
    .sw     (!key),
    .db_tick(key_tick)
  );

  // Playback state, divider, index and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  // Next-state: start/abort on key, advance one sample every DIV clocks.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_tick) begin
          state_d = LOAD;
          idx_d   = '0;
          div_d   = '0;
        end
      end
      LOAD: begin
        if (key_tick) begin
          state_d = IDLE;
          out_d   = '0;
          idx_d   = '0;
          div_d   = '0;
        end else begin
          state_d = PLAY;
          out_d   = rd_data;
          idx_d   = '0;
          div_d   = '0;
        end
      end
      PLAY: begin
        if (key_tick) begin
          state_d = IDLE;
          out_d   = '0;
          idx_d   = '0;
          div_d   = '0;
        end else if (div_q == DW'(DIV - 1)) begin
          div_d = '0;
          if (idx_q == AW'(DEPTH - 1) && !loop_en) begin
            state_d = IDLE;
            out_d   = '0;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            out_d = rd_data;
            idx_d = nxt_idx;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        out_d   = '0;
        idx_d   = '0;
        div_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_logic_pattern_gen.sv
// Randomized self-checking bench for logic_pattern_gen (small DEPTH/DIV).
module tb_logic_pattern_gen;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned CH    = 4;
  localparam int unsigned DIV   = 4;
  localparam int unsigned DB    = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          key;
  logic          loop_en;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [CH-1:0] wr_data;
  logic [CH-1:0] out;
  logic          busy;
  logic          done_tick;
  logic [AW-1:0] sample_idx;

  int unsigned n_checks = 0;
  int unsigned n_errs   = 0;

  // Reference pattern memory as the host believes it to be.
  logic [CH-1:0] pat [DEPTH];

  logic_pattern_gen #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .CH       (CH),
    .DIV      (DIV),
    .DB_CYCLES(DB)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key       (key),
    .loop_en   (loop_en),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .out       (out),
    .busy      (busy),
    .done_tick (done_tick),
    .sample_idx(sample_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic host_write(input int unsigned a, input int unsigned d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = CH'(d);
    if (a < DEPTH) pat[a] = CH'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic idle_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge clk);
  endtask

  // Hold key low until the debounced tick appears (bounded); key stays low.
  task automatic press_key();
    bit seen;
    seen = 1'b0;
    key  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dut.key_tick) begin
        seen = 1'b1;
        break;
      end
    end
    check("key_tick_seen", 32'(seen), 32'd1);
  endtask

  // Follows a press: checks LOAD, then ncyc cycles of playback against the
  // pattern model. Optional random writes land only early in a sample, and an
  // optional directed write happens at cycle dir_n.
  task automatic run_play(input int unsigned ncyc, input bit rnd_wr,
                          input int unsigned dir_n, input int unsigned dir_a,
                          input int unsigned dir_d);
    logic [CH-1:0] cur;
    int unsigned   k, s, a, d;
    cur = '0;
    @(negedge clk);
    check("load_busy", 32'(busy), 32'd1);
    check("load_out", 32'(out), 32'd0);
    key = 1'b1;
    for (int unsigned n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      wr_en = 1'b0;
      k = n - 1;
      s = k / DIV;
      if (!loop_en && s >= DEPTH) begin
        check("end_done", 32'(done_tick), (k == DEPTH * DIV) ? 32'd1 : 32'd0);
        check("end_out", 32'(out), 32'd0);
        check("end_busy", 32'(busy), 32'd0);
        check("end_idx", 32'(sample_idx), 32'd0);
      end else begin
        if (k % DIV == 0) cur = pat[s % DEPTH];
        check("play_out", 32'(out), 32'(cur));
        check("play_busy", 32'(busy), 32'd1);
        check("play_done", 32'(done_tick), 32'd0);
        check("play_idx", 32'(sample_idx), 32'(s % DEPTH));
        if (n == dir_n) begin
          wr_en = 1'b1; wr_addr = AW'(dir_a); wr_data = CH'(dir_d);
          if (dir_a < DEPTH) pat[dir_a] = CH'(dir_d);
        end else if (rnd_wr && (k % DIV) <= DIV - 3 && $urandom_range(0, 3) == 0) begin
          a = $urandom_range(0, 2**AW - 1);
          d = $urandom_range(0, 2**CH - 1);
          wr_en = 1'b1; wr_addr = AW'(a); wr_data = CH'(d);
          if (a < DEPTH) pat[a] = CH'(d);
        end
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  int unsigned rises;

  initial begin
    reset_n = 1'b0;
    key     = 1'b1;
    loop_en = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    idle_cycles(3);
    check("rst_out", 32'(out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done_tick), 32'd0);
    check("rst_idx", 32'(sample_idx), 32'd0);
    reset_n = 1'b1;
    idle_cycles(3);

    // 1: pattern 1..8, single shot
    for (int unsigned i = 0; i < DEPTH; i++) host_write(i, i + 1);
    idle_cycles(2);
    press_key();
    run_play(DEPTH * DIV + 4, 1'b0, 0, 0, 0);

    // 2: random pattern, looping with random writes, then abort
    for (int unsigned i = 0; i < DEPTH; i++) host_write(i, $urandom_range(0, 15));
    loop_en = 1'b1;
    idle_cycles(2);
    press_key();
    run_play(2 * DEPTH * DIV + 3 * DIV + 1, 1'b1, 0, 0, 0);
    press_key();
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out", 32'(out), 32'd0);
    check("abort_done", 32'(done_tick), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done_tick), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
    end
    key     = 1'b1;
    loop_en = 1'b0;
    idle_cycles(DB + 4);

    // 3: pattern 1..8; while 0x3 plays write addr 4 = 0xF; then addr 9 ignored
    for (int unsigned i = 0; i < DEPTH; i++) host_write(i, i + 1);
    idle_cycles(2);
    press_key();
    run_play(DEPTH * DIV + 2, 1'b0, 2 * DIV + 1, 4, 15);
    host_write(9, 0);
    host_write(1, 6);
    host_write(9, 12);
    idle_cycles(2);
    press_key();
    run_play(DEPTH * DIV + 2, 1'b0, 0, 0, 0);

    // 4: asynchronous reset in the middle of sample 5
    idle_cycles(2);
    press_key();
    run_play(4 * DIV + 1, 1'b1, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_out", 32'(out), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_idx", 32'(sample_idx), 32'd0);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 3 * DB; i++) begin
      @(negedge clk);
      check("post_rst_idle", 32'(busy), 32'd0);
      check("post_rst_out", 32'(out), 32'd0);
    end

    // 5: bouncy key through the real debouncer -> exactly one run
    rises = 0;
    fork
      begin
        logic prev;
        prev = busy;
        for (int i = 0; i < 250; i++) begin
          @(negedge clk);
          if (busy && !prev) rises++;
          prev = busy;
        end
      end
      begin
        for (int i = 0; i < 9; i++) begin
          key = ~key;
          idle_cycles($urandom_range(1, 3));
        end
        idle_cycles(4 * DB);
        for (int i = 0; i < 5; i++) begin
          key = ~key;
          idle_cycles($urandom_range(1, 3));
        end
      end
    join
    check("bounce_runs", 32'(rises), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
